// File: rtl/matrix_exec_unit_pkg.sv
// Shared encodings for the matrix execution unit.
//   MX_OP_*  : command opcodes carried on cmd_op
//   MX_SRC_* : WRITE data source select carried on cmd_src
//   mx_state_e : MOPA sequencer states
package matrix_exec_unit_pkg;

    localparam logic [1:0] MX_OP_WRITE = 2'b00;
    localparam logic [1:0] MX_OP_READ  = 2'b01;
    localparam logic [1:0] MX_OP_MOPA  = 2'b10;
    localparam logic [1:0] MX_OP_CLEAR = 2'b11;

    localparam logic MX_SRC_MEM = 1'b0;
    localparam logic MX_SRC_REG = 1'b1;

    typedef enum logic {
        MX_ST_IDLE = 1'b0,
        MX_ST_RUN  = 1'b1
    } mx_state_e;

endpackage

// File: rtl/mopa_row_mac.sv
// One row of the outer-product accumulate: row_out[j] = row_in[j] + sext(a*b[j]).
// Purely combinational; the top muxes the active row in and out.
//   row_in  : N accumulators of the row being updated
//   a_elem  : signed int8 a[i] for that row
//   b_vec   : packed signed int8 vector b
//   row_out : N updated accumulators (wrap modulo 2^W)
module mopa_row_mac #(
    parameter int N = 4,
    parameter int W = 32
) (
    input  logic [N-1:0][W-1:0] row_in,
    input  logic [7:0]          a_elem,
    input  logic [N-1:0][7:0]   b_vec,
    output logic [N-1:0][W-1:0] row_out
);

    for (genvar j = 0; j < N; j++) begin : g_col
        logic signed [15:0] prod;
        // int8 x int8 always fits in 16 bits signed
        assign prod       = $signed(a_elem) * $signed(b_vec[j]);
        assign row_out[j] = row_in[j] + {{(W-16){prod[15]}}, prod};
    end

endmodule

// File: rtl/matrix_exec_unit.sv
// Matrix register file (N x N, W-bit) with element WRITE/READ, CLEAR and a
// multi-cycle MOPA outer-product accumulate processed one row per cycle.
//   clk, rst           : clock, asynchronous active-high reset
//   cmd_valid/ready    : command handshake; ready is low while MOPA runs
//   cmd_op, cmd_src    : opcode and WRITE source select
//   cmd_row, cmd_col   : element index for WRITE/READ
//   cmd_mem_data       : WRITE data from memory stage
//   cmd_reg_data(2)    : WRITE data from rs1 / MOPA vectors a (rs1), b (rs2)
//   rd_valid, rd_data  : READ result, one cycle after accept; data held
//   busy, mopa_done    : MOPA in progress / one-cycle completion pulse
module matrix_exec_unit
    import matrix_exec_unit_pkg::*;
#(
    parameter int N    = 4,
    parameter int W    = 32,
    parameter int IDXW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_op,
    input  logic            cmd_src,
    input  logic [IDXW-1:0] cmd_row,
    input  logic [IDXW-1:0] cmd_col,
    input  logic [W-1:0]    cmd_mem_data,
    input  logic [W-1:0]    cmd_reg_data,
    input  logic [W-1:0]    cmd_reg_data2,
    output logic            rd_valid,
    output logic [W-1:0]    rd_data,
    output logic            busy,
    output logic            mopa_done
);

    mx_state_e                  state;
    logic [IDXW-1:0]            cnt;
    logic [N-1:0][7:0]          a_lat;
    logic [N-1:0][7:0]          b_lat;
    logic [N-1:0][N-1:0][W-1:0] mat;
    logic [N-1:0][W-1:0]        mac_out;

    logic         accept;
    logic         idx_ok;
    logic         last_row;
    logic [W-1:0] wr_data;

    // ready depends on state only, never on cmd_valid
    assign busy      = (state == MX_ST_RUN);
    assign cmd_ready = !busy;
    assign accept    = cmd_valid && cmd_ready;

    // Only matters when N is not a power of two
    assign idx_ok   = (int'(cmd_row) < N) && (int'(cmd_col) < N);
    assign last_row = (int'(cnt) == N - 1);
    assign wr_data  = (cmd_src == MX_SRC_REG) ? cmd_reg_data : cmd_mem_data;

    mopa_row_mac #(
        .N (N),
        .W (W)
    ) u_mac (
        .row_in  (mat[cnt]),
        .a_elem  (a_lat[cnt]),
        .b_vec   (b_lat),
        .row_out (mac_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= MX_ST_IDLE;
            cnt       <= '0;
            a_lat     <= '0;
            b_lat     <= '0;
            mat       <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            mopa_done <= 1'b0;
        end else begin
            rd_valid  <= 1'b0;
            mopa_done <= 1'b0;
            case (state)
                MX_ST_IDLE: begin
                    if (accept) begin
                        case (cmd_op)
                            MX_OP_WRITE: begin
                                if (idx_ok) mat[cmd_row][cmd_col] <= wr_data;
                            end
                            MX_OP_READ: begin
                                rd_valid <= 1'b1;
                                rd_data  <= idx_ok ? mat[cmd_row][cmd_col] : '0;
                            end
                            MX_OP_MOPA: begin
                                // operands captured here; ports are free during RUN
                                a_lat <= cmd_reg_data[N*8-1:0];
                                b_lat <= cmd_reg_data2[N*8-1:0];
                                cnt   <= '0;
                                state <= MX_ST_RUN;
                            end
                            MX_OP_CLEAR: mat <= '0;
                            default: ;
                        endcase
                    end
                end
                MX_ST_RUN: begin
                    mat[cnt] <= mac_out;
                    if (last_row) begin
                        state     <= MX_ST_IDLE;
                        cnt       <= '0;
                        mopa_done <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= MX_ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/matrix_exec_unit.md
# matrix_exec_unit

Matrix register file and outer-product engine that executes the matrix-class control decisions produced by instruction decode (element load from memory, element move from scalar register, element read-back to a scalar register, and the MOPA accumulate). It sits beside the integer datapath in the EX/MEM stages and holds an N×N array of W-bit accumulators. Single-cycle moves and clears complete immediately. MOPA runs as a multi-cycle, one-row-per-cycle operation behind a valid/ready handshake that stalls the issuing pipeline.

## Interface
- N, 4: matrix dimension, rows × cols; constraint N*8 ≤ W
- W, 32: element width and scalar register width
- IDXW, $clog2(N): row/column index width
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  unit can accept a command (= !busy)
- cmd_op  in  2  00 WRITE, 01 READ, 10 MOPA, 11 CLEAR
- cmd_src  in  1  WRITE source: 0 = cmd_mem_data (matrix load), 1 = cmd_reg_data (reg→matrix move)
- cmd_row, cmd_col  in  IDXW each  element index for WRITE/READ
- cmd_mem_data  in  W  load data from memory stage
- cmd_reg_data  in  W  rs1 value; for MOPA, packed signed int8 vector a, with a[i] = bits [8i+7:8i]
- cmd_reg_data2  in  W  rs2 value; for MOPA, packed signed int8 vector b
- rd_valid  out  1  one-cycle pulse, rd_data is valid
- rd_data  out  W  element read result, held until the next READ
- busy  out  1  MOPA in progress
- mopa_done  out  1  one-cycle pulse after MOPA completes

## Operation
- A command is accepted when cmd_valid && cmd_ready. Commands presented while not ready have no effect; the issuer holds them stable.
- WRITE: M[row][col] ← selected source, full W bits.
- READ: rd_data ← M[row][col], registered; rd_valid pulses.
- CLEAR: all N*N elements are zeroed in one edge.
- MOPA: C[i][j] ← C[i][j] + sext(a[i]) * sext(b[j]).
  - Each product is a signed 16-bit value, sign-extended to W.
  - The sum wraps modulo 2^W; there is no saturation or flag.
  - a and b are latched at acceptance, so later changes on the ports have no effect.
- FSM states:
  - IDLE → RUN on MOPA accept. The row counter is cleared to 0.
  - In RUN, each edge updates row cnt (all N columns in parallel) and then increments cnt.
  - RUN → IDLE on the edge that updates row N-1.
- Only CLEAR, WRITE and MOPA change the array. The array changes only on accepted commands or MOPA RUN edges.
- Reset values (asynchronous):
  - array all 0, state IDLE, cnt 0
  - busy 0, cmd_ready 1
  - rd_valid 0, rd_data 0, mopa_done 0
- Reset asserted mid-MOPA aborts the operation. The array is zeroed and no mopa_done is produced.
- Indices ≥ N cannot occur when N is a power of two. Otherwise WRITE to an index ≥ N is dropped and READ of an index ≥ N returns 0.

## Timing
- WRITE/CLEAR accepted in cycle t: the array is updated at the end of t. A READ accepted in t+1 returns the new value.
- READ accepted in t: rd_valid = 1 and rd_data valid in t+1.
- Back-to-back READs give consecutive rd_valid pulses.
- MOPA accepted in cycle t:
  - busy = 1 and cmd_ready = 0 in cycles t+1 … t+N.
  - Row k is updated at the end of cycle t+1+k.
  - mopa_done = 1 in t+N+1, the same cycle busy falls.
  - The next command can be accepted in t+N+1 and sees the full result.
- Total MOPA occupancy is N+1 cycles including the accept cycle.
- cmd_ready is a pure function of state, with no combinational path from cmd_valid.

## Structure
- Shared defines (alongside the existing opcode/funct3 defines): MX_OP_WRITE/READ/MOPA/CLEAR encodings, MX_SRC_MEM/MX_SRC_REG, FSM state encodings.
- One sub-module, mopa_row_mac. Inputs: one row of N accumulators, scalar a[i], vector b. Outputs: N updated accumulators. It is purely combinational and instantiated once, muxed by cnt.

## Test plan
- Reset mid-MOPA: set C[0][0]=5 via WRITE, issue MOPA, assert rst in busy cycle 2 → all outputs at reset values, READ C[0][0] afterwards = 0, no mopa_done.
- WRITE mem 0xDEADBEEF to (2,3), WRITE reg 0x12345678 to (0,1), READ both → rd_data 0xDEADBEEF then 0x12345678, each one cycle after accept; CLEAR then READ (2,3) → 0.
- CLEAR, MOPA with a=0x04_03_02_01, b=0xFF_02_01_01 (b = {-1,2,1,1}) → C[1][2]=4, C[3][3]=-4 (0xFFFFFFFC), C[0][0]=1; busy exactly 4 cycles, mopa_done in cycle t+5.
- Wrap: WRITE C[0][0]=0x7FFFFFFF, MOPA a[0]=b[0]=0x7F → C[0][0]=0x80003F00.
- Handshake: hold cmd_valid with READ during busy → not accepted until cmd_ready=1, then accepted in t+N+1 and returns the post-MOPA value; change cmd_reg_data during busy → result unchanged.
